// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command-side driver for an 8-bit ALU. Each accepted command issues one ALU
//   operation with the accumulator as A and the command data as B. The ALU result
//   is written back into the accumulator. A command flagged last returns the final
//   accumulator, the op count and an overflow flag on a valid/ready response channel.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op/cmd_data/cmd_last    ALU sel code, B operand, end-of-sequence flag
//   alu_sel/alu_a/alu_b         registered ALU drive (A = accumulator)
//   alu_y                       combinational ALU result
//   res_valid/res_ready         response handshake
//   res_data/res_ops/res_ovf    final accumulator, op count (saturating), overflow
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_OPS = 16,
  localparam int unsigned CW     = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_last,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [CW-1:0]    res_ops,
  output logic             res_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_OPS);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic             ovf_q;
  logic             last_q;
  logic             at_max;

  // Ready is a pure state decode, gated by rst_n so it is low for the whole
  // time reset is asserted rather than only after the first edge.
  assign cmd_ready = (state == IDLE) && rst_n;
  assign at_max    = (count == MAX_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf_q     <= 1'b0;
      last_q    <= 1'b0;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ops   <= '0;
      res_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_sel <= cmd_op;
            alu_a   <= acc;
            alu_b   <= cmd_data;
            last_q  <= cmd_last;
            state   <= EXEC;
          end
        end
        EXEC: begin
          acc <= alu_y;
          if (at_max) begin
            ovf_q <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
          if (last_q) begin
            res_data  <= alu_y;
            res_ops   <= at_max ? count : count + CW'(1);
            res_ovf   <= ovf_q | at_max;
            res_valid <= 1'b1;
            state     <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf_q     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_last;
  logic [2:0] alu_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [4:0] res_ops;
  logic       res_ovf;

  int errors = 0;
  int checks = 0;

  logic [2:0] last_op;
  logic [7:0] last_d;

  logic [2:0] seq_op[64];
  logic [7:0] seq_d[64];

  typedef struct {
    logic [2:0] op1;
    logic [7:0] d1;
    logic [2:0] op2;
    logic [7:0] d2;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[10];

  alu_cmd_sequencer #(.WIDTH(8), .MAX_OPS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_last  (cmd_last),
    .alu_sel   (alu_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ops   (res_ops),
    .res_ovf   (res_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The ALU being driven, plus the reference arithmetic for one op.
  function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0:    return 8'h00;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a + b;
      3'd4:    return a - b;
      3'd5:    return a ^ b;
      3'd6:    return ~a;
      default: return 8'hFF;
    endcase
  endfunction

  always_comb alu_y = alu_f(alu_sel, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns one time unit after the accepting edge (sequencer is then in EXEC).
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] d, input logic last);
    int unsigned n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_last  = last;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    last_op = op;
    last_d  = d;
  endtask

  task automatic get_resp(input logic [7:0] ed, input logic [4:0] eo, input logic ev, input int unsigned hold);
    int unsigned n;
    @(negedge clk);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("res_valid", 32'(res_valid), 32'd1);
    check("res_data", 32'(res_data), 32'(ed));
    check("res_ops", 32'(res_ops), 32'(eo));
    check("res_ovf", 32'(res_ovf), 32'(ev));
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'(ed));
      check("hold_ops", 32'(res_ops), 32'(eo));
      check("hold_ready", 32'(cmd_ready), 32'd0);
      check("hold_alu_sel", 32'(alu_sel), 32'(last_op));
      check("hold_alu_b", 32'(alu_b), 32'(last_d));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("res_valid_drop", 32'(res_valid), 32'd0);
    check("ready_after_resp", 32'(cmd_ready), 32'd1);
  endtask

  // Reference: fold the ops over a zero accumulator; count saturates at 16.
  task automatic run_seq(input int unsigned len, input int unsigned hold);
    logic [7:0] m;
    m = 8'h00;
    for (int unsigned i = 0; i < len; i++) begin
      send_cmd(seq_op[i], seq_d[i], i == len - 1);
      m = alu_f(seq_op[i], m, seq_d[i]);
    end
    get_resp(m, (len > 16) ? 5'd16 : 5'(len), len > 16, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{3'd3, 8'h4F, 3'd0, 8'h1F, 8'h00};
    tbl[1] = '{3'd3, 8'h4F, 3'd1, 8'h1F, 8'h0F};
    tbl[2] = '{3'd3, 8'h4F, 3'd2, 8'h1F, 8'h5F};
    tbl[3] = '{3'd3, 8'h4F, 3'd3, 8'h1F, 8'h6E};
    tbl[4] = '{3'd3, 8'h4F, 3'd4, 8'h1F, 8'h30};
    tbl[5] = '{3'd3, 8'h4F, 3'd5, 8'h1F, 8'h50};
    tbl[6] = '{3'd3, 8'h4F, 3'd6, 8'h1F, 8'hB0};
    tbl[7] = '{3'd3, 8'h4F, 3'd7, 8'h1F, 8'hFF};
    tbl[8] = '{3'd3, 8'h80, 3'd3, 8'h80, 8'h00};
    tbl[9] = '{3'd3, 8'hF0, 3'd4, 8'hF1, 8'hFF};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_data = 8'h00;
    cmd_last = 1'b0;
    res_ready = 1'b0;
    last_op = 3'd0;
    last_d = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_ovf", 32'(res_ovf), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_ops", 32'(res_ops), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(cmd_ready), 32'd1);

    // add 0x4F, and 0x1F last, with latency check
    send_cmd(3'd3, 8'h4F, 1'b0);
    send_cmd(3'd1, 8'h1F, 1'b1);
    check("exec_ready", 32'(cmd_ready), 32'd0);
    check("exec_alu_a", 32'(alu_a), 32'h4F);
    @(negedge clk);
    check("lat_not_yet", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(res_valid), 32'd1);
    get_resp(8'h0F, 5'd2, 1'b0, 0);

    // sub wrap, then accumulator cleared for the next sequence
    send_cmd(3'd4, 8'h01, 1'b1);
    get_resp(8'hFF, 5'd1, 1'b0, 0);
    send_cmd(3'd3, 8'h05, 1'b1);
    get_resp(8'h05, 5'd1, 1'b0, 0);

    // response back-pressure for 5 cycles
    send_cmd(3'd3, 8'h33, 1'b1);
    get_resp(8'h33, 5'd1, 1'b0, 5);

    // 17 ops: count saturates, overflow flagged
    for (int unsigned i = 0; i < 17; i++) send_cmd(3'd3, 8'h01, i == 16);
    get_resp(8'h11, 5'd16, 1'b1, 0);
    // exactly 16 ops: no overflow
    for (int unsigned i = 0; i < 16; i++) send_cmd(3'd3, 8'h02, i == 15);
    get_resp(8'h20, 5'd16, 1'b0, 0);

    for (int unsigned i = 0; i < 10; i++) begin
      send_cmd(tbl[i].op1, tbl[i].d1, 1'b0);
      send_cmd(tbl[i].op2, tbl[i].d2, 1'b1);
      get_resp(tbl[i].exp, 5'd2, 1'b0, 0);
    end

    // reset while in EXEC
    send_cmd(3'd3, 8'h10, 1'b0);
    send_cmd(3'd3, 8'h20, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rexec_valid", 32'(res_valid), 32'd0);
    check("rexec_ready", 32'(cmd_ready), 32'd0);
    check("rexec_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(3'd3, 8'h03, 1'b1);
    get_resp(8'h03, 5'd1, 1'b0, 0);

    // reset while in RESP
    send_cmd(3'd3, 8'h44, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rresp_pre", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rresp_valid", 32'(res_valid), 32'd0);
    check("rresp_data", 32'(res_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(3'd3, 8'h07, 1'b1);
    get_resp(8'h07, 5'd1, 1'b0, 0);

    // randomized sequences against the fold model
    for (int unsigned s = 0; s < 40; s++) begin
      int unsigned len;
      len = $urandom_range(1, 20);
      for (int unsigned i = 0; i < len; i++) begin
        seq_op[i] = 3'($urandom_range(0, 7));
        seq_d[i]  = 8'($urandom);
      end
      run_seq(len, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
